lcd_hd44780_responder: RTL and testbench



---
 rtl/lcd_hd44780_pkg.sv | 55 +++++
 rtl/lcd_hd44780_responder_ddram.sv | 27 ++
 rtl/lcd_hd44780_responder.sv | 170 +++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, state type and address-counter helpers for the HD44780 responder.
package lcd_hd44780_pkg;

    localparam int unsigned DDRAM_DEPTH = 128;
    localparam int unsigned FILL_COUNT  = 80;

    // DDRAM line windows; everything outside them is unused on a 2x40 panel
    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE0_LIMIT = 7'h27;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE1_LIMIT = 7'h67;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Instruction opcode masks; decode picks the highest set bit
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StClearFill
    } state_e;

    // Next address counter value, wrapping between the two line windows
    function automatic logic [6:0] ac_step(input logic [6:0] cur, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (cur == LINE0_LIMIT)      nxt = LINE1_BASE;
            else if (cur == LINE1_LIMIT) nxt = LINE0_BASE;
            else                         nxt = cur + 7'd1;
        end else begin
            if (cur == LINE0_BASE)       nxt = LINE1_LIMIT;
            else if (cur == LINE1_BASE)  nxt = LINE0_LIMIT;
            else                         nxt = cur - 7'd1;
        end
        return nxt;
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= LINE0_LIMIT) || ((a >= LINE1_BASE) && (a <= LINE1_LIMIT));
    endfunction

    // Map fill index 0..79 onto 0x00-0x27 then 0x40-0x67
    function automatic logic [6:0] fill_addr(input logic [6:0] idx);
        return (idx <= LINE0_LIMIT) ? idx : idx + (LINE1_BASE - LINE0_LIMIT - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_ddram.sv
// 128x8 display data RAM: one write port, two combinational read ports (bus, debug).
module lcd_hd44780_responder_ddram
    import lcd_hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] addr_a,
    output logic [7:0] data_a,
    input  logic [6:0] addr_b,
    output logic [7:0] data_b
);

    logic [7:0] mem [DDRAM_DEPTH];

    // Storage is deliberately not reset; contents survive a reset like the real panel
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign data_a = mem[addr_a];
    assign data_b = mem[addr_b];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible character LCD responder: samples the E/RS/RW/data bus,
// maintains DDRAM, address counter and busy flag, and answers reads.
module lcd_hd44780_responder
    import lcd_hd44780_pkg::*;
#(
    parameter int unsigned BUSY_SHORT = 40,
    parameter int unsigned BUSY_LONG  = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       err,
    output logic       display_on,
    output logic [6:0] ac,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic        e_q;
    logic        rs_q;
    logic        rw_q;
    logic [7:0]  data_q;
    logic [7:0]  rd_out_q;
    logic [15:0] busy_cnt_q;
    logic [6:0]  ac_q;
    logic [6:0]  fill_idx_q;
    logic        inc_q;
    logic        shift_q;
    logic        err_q;
    logic        disp_q;
    state_e      state_q;

    logic        bf;
    logic        commit;
    logic        mem_we;
    logic [6:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    assign bf     = (busy_cnt_q != 16'd0);
    // Falling edge of E commits whatever was captured while E was high
    assign commit = e_q & ~lcd_e;

    lcd_hd44780_responder_ddram u_ddram (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .addr_a (ac_q),
        .data_a (mem_rdata),
        .addr_b (dbg_addr),
        .data_b (dbg_data)
    );

    // DDRAM write port: clear-fill owns it while active, otherwise committed data writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ac_q;
        mem_wdata = data_q;
        if (state_q == StClearFill) begin
            mem_we    = !reset;
            mem_waddr = fill_addr(fill_idx_q);
            mem_wdata = BLANK_CHAR;
        end else if (commit && !rw_q && rs_q && !bf) begin
            mem_we = !reset;
        end
    end

    // Bus sampling, instruction decode, busy counter and state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            rd_out_q   <= 8'h00;
            busy_cnt_q <= 16'd0;
            ac_q       <= 7'h00;
            fill_idx_q <= 7'd0;
            inc_q      <= 1'b1;
            shift_q    <= 1'b0;
            err_q      <= 1'b0;
            disp_q     <= 1'b0;
            state_q    <= StIdle;
        end else begin
            e_q <= lcd_e;
            if (lcd_e) begin
                rs_q     <= lcd_rs;
                rw_q     <= lcd_rw;
                data_q   <= lcd_data_in;
                rd_out_q <= lcd_rs ? mem_rdata : {bf, ac_q};
            end

            if (bf) begin
                busy_cnt_q <= busy_cnt_q - 16'd1;
            end

            if (commit) begin
                if (rw_q) begin
                    // Reads are honoured while busy; only data reads move AC
                    if (rs_q) begin
                        ac_q <= ac_step(ac_q, inc_q);
                    end
                end else if (bf) begin
                    err_q <= 1'b1;
                end else begin
                    busy_cnt_q <= 16'(BUSY_SHORT);
                    state_q    <= StBusy;
                    if (rs_q) begin
                        ac_q <= ac_step(ac_q, inc_q);
                    end else if (|(data_q & OP_DDRAM)) begin
                        if (ac_valid(data_q[6:0])) begin
                            ac_q <= data_q[6:0];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (|(data_q & (OP_CGRAM | OP_FUNCSET | OP_SHIFT))) begin
                        // Accepted without side effects beyond the busy time
                    end else if (|(data_q & OP_DISPLAY)) begin
                        disp_q <= data_q[2];
                    end else if (|(data_q & OP_ENTRY)) begin
                        inc_q   <= data_q[1];
                        shift_q <= data_q[0];
                    end else if (|(data_q & OP_HOME)) begin
                        ac_q       <= 7'h00;
                        busy_cnt_q <= 16'(BUSY_LONG);
                    end else if (|(data_q & OP_CLEAR)) begin
                        busy_cnt_q <= 16'(BUSY_LONG);
                        fill_idx_q <= 7'd0;
                        state_q    <= StClearFill;
                    end
                end
            end

            unique case (state_q)
                StClearFill: begin
                    if (fill_idx_q == 7'(FILL_COUNT - 1)) begin
                        fill_idx_q <= 7'd0;
                        ac_q       <= 7'h00;
                        inc_q      <= 1'b1;
                        state_q    <= StBusy;
                    end else begin
                        fill_idx_q <= fill_idx_q + 7'd1;
                    end
                end
                StBusy: begin
                    if (busy_cnt_q <= 16'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lcd_data_out = rd_out_q;
    assign lcd_data_oe  = e_q & rw_q;
    assign busy         = bf;
    assign err          = err_q;
    assign display_on   = disp_q;
    assign ac           = ac_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder against a linear-position reference model.
module tb_lcd_hd44780_responder;

    localparam int unsigned BUSY_SHORT = 40;
    localparam int unsigned BUSY_LONG  = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic       busy;
    logic       err;
    logic       display_on;
    logic [6:0] ac;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_ddram [128];
    logic [6:0] m_ac;
    logic       m_id;
    logic       m_err;
    logic       m_disp;

    lcd_hd44780_responder #(
        .BUSY_SHORT (BUSY_SHORT),
        .BUSY_LONG  (BUSY_LONG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_e        (lcd_e),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .busy         (busy),
        .err          (err),
        .display_on   (display_on),
        .ac           (ac),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Visible cells form an 80-position ring: positions 0..39 -> 0x00.., 40..79 -> 0x40..
    function automatic int pos_of(input logic [6:0] a);
        return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
    endfunction

    function automatic logic [6:0] addr_of(input int p);
        return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
        int p;
        p = pos_of(a);
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return addr_of(p);
    endfunction

    function automatic logic is_visible(input logic [6:0] a);
        return (a < 7'd40) || (a >= 7'd64 && a < 7'd104);
    endfunction

    // Model of an accepted (not-busy) write
    task automatic m_write(input logic rs, input logic [7:0] d);
        if (rs) begin
            m_ddram[m_ac] = d;
            m_ac = m_step(m_ac, m_id);
        end else if (d[7]) begin
            if (is_visible(d[6:0])) m_ac = d[6:0];
            else m_err = 1'b1;
        end else if (d[6] | d[5] | d[4]) begin
        end else if (d[3]) begin
            m_disp = d[2];
        end else if (d[2]) begin
            m_id = d[1];
        end else if (d[1]) begin
            m_ac = 7'h00;
        end else if (d[0]) begin
            for (int p = 0; p < 80; p++) m_ddram[addr_of(p)] = 8'h20;
            m_ac = 7'h00;
            m_id = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lcd_e = 1'b0;
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
        lcd_data_in = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ac = 7'h00;
        m_id = 1'b1;
        m_err = 1'b0;
        m_disp = 1'b0;
    endtask

    // E high for two cycles, then low; returns just after the commit edge
    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs;
        lcd_rw = 1'b0;
        lcd_data_in = d;
        lcd_e = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lcd_e = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // oe_trace = {before E, first E-high cycle, at E fall, after commit edge}
    task automatic bus_read(input logic rs, output logic [7:0] d, output logic [3:0] oe_trace);
        @(negedge clk);
        oe_trace[3] = lcd_data_oe;
        lcd_rs = rs;
        lcd_rw = 1'b1;
        lcd_data_in = $urandom_range(0, 255);
        lcd_e = 1'b1;
        @(negedge clk);
        oe_trace[2] = lcd_data_oe;
        @(negedge clk);
        d = lcd_data_out;
        oe_trace[1] = lcd_data_oe;
        lcd_e = 1'b0;
        @(posedge clk);
        #1;
        oe_trace[0] = lcd_data_oe;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [3:0] tr;
        do_reset();
        #1;
        checks++;
        if ({lcd_data_out, lcd_data_oe, busy, err, display_on, ac} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h oe=%b busy=%b err=%b disp=%b ac=%h, required all 0",
                     lcd_data_out, lcd_data_oe, busy, err, display_on, ac);
        end
        bus_read(1'b0, d, tr);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %h required 00", d);
        end
        checks++;
        if (tr !== 4'b0110) begin
            errors++;
            $display("FAIL read_oe_window: got %b required 0110", tr);
        end
    endtask

    task automatic test_write_basic();
        int n;
        bus_write(1'b0, 8'h80);
        m_write(1'b0, 8'h80);
        wait_idle();
        bus_write(1'b1, 8'h41);
        m_write(1'b1, 8'h41);
        count_busy(n);
        checks++;
        if (n != int'(BUSY_SHORT)) begin
            errors++;
            $display("FAIL busy_short_len: got %0d required %0d", n, BUSY_SHORT);
        end
        dbg_addr = 7'h00;
        #1;
        checks++;
        if (dbg_data !== m_ddram[0] || ac !== m_ac) begin
            errors++;
            $display("FAIL data_write: ddram0=%h ac=%h required %h %h", dbg_data, ac, m_ddram[0], m_ac);
        end
    endtask

    task automatic test_wrap();
        bus_write(1'b0, 8'hA7);  m_write(1'b0, 8'hA7);  wait_idle();
        bus_write(1'b1, 8'h42);  m_write(1'b1, 8'h42);  wait_idle();
        dbg_addr = 7'h27;
        #1;
        checks++;
        if (dbg_data !== 8'h42 || ac !== 7'h40) begin
            errors++;
            $display("FAIL wrap_inc: ddram27=%h ac=%h required 42 40", dbg_data, ac);
        end
        bus_write(1'b0, 8'h04);  m_write(1'b0, 8'h04);  wait_idle();
        bus_write(1'b0, 8'hC0);  m_write(1'b0, 8'hC0);  wait_idle();
        bus_write(1'b1, 8'h43);  m_write(1'b1, 8'h43);  wait_idle();
        dbg_addr = 7'h40;
        #1;
        checks++;
        if (dbg_data !== 8'h43 || ac !== 7'h27 || ac !== m_ac) begin
            errors++;
            $display("FAIL wrap_dec: ddram40=%h ac=%h required 43 27", dbg_data, ac);
        end
    endtask

    task automatic test_clear();
        int n;
        logic [7:0] d;
        logic [3:0] tr;
        bus_write(1'b0, 8'h01);
        m_write(1'b0, 8'h01);
        count_busy(n);
        checks++;
        if (n != int'(BUSY_LONG)) begin
            errors++;
            $display("FAIL busy_long_len: got %0d required %0d", n, BUSY_LONG);
        end
        for (int p = 0; p < 80; p++) begin
            dbg_addr = addr_of(p);
            #1;
            checks++;
            if (dbg_data !== 8'h20) begin
                errors++;
                $display("FAIL clear_fill[%h]: got %h required 20", dbg_addr, dbg_data);
            end
        end
        checks++;
        if (ac !== 7'h00) begin
            errors++;
            $display("FAIL clear_ac: got %h required 00", ac);
        end
        // Clear must restore increment mode and report busy during the fill
        bus_write(1'b0, 8'h04);  m_write(1'b0, 8'h04);  wait_idle();
        bus_write(1'b0, 8'h01);  m_write(1'b0, 8'h01);
        bus_read(1'b0, d, tr);
        checks++;
        if (d[7] !== 1'b1) begin
            errors++;
            $display("FAIL clear_status_bf: got %h required bit7=1", d);
        end
        wait_idle();
        bus_write(1'b1, 8'h55);  m_write(1'b1, 8'h55);  wait_idle();
        checks++;
        if (ac !== 7'h01 || ac !== m_ac) begin
            errors++;
            $display("FAIL clear_restores_inc: ac=%h required 01", ac);
        end
    endtask

    task automatic test_busy_write();
        bus_write(1'b0, 8'h90);  m_write(1'b0, 8'h90);  wait_idle();
        bus_write(1'b1, 8'h11);  m_write(1'b1, 8'h11);
        bus_write(1'b1, 8'h22);  m_err = 1'b1;
        dbg_addr = 7'h10;
        #1;
        checks++;
        if (dbg_data !== 8'h11 || ac !== m_ac || err !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_ignored: ddram10=%h ac=%h err=%b required 11 %h 1",
                     dbg_data, ac, err, m_ac);
        end
        wait_idle();
        bus_write(1'b1, 8'h33);  m_write(1'b1, 8'h33);  wait_idle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        do_reset();
        dbg_addr = 7'h11;
        #1;
        checks++;
        if (err !== 1'b0 || dbg_data !== m_ddram[7'h11]) begin
            errors++;
            $display("FAIL reset_err_ddram: err=%b ddram11=%h required 0 %h",
                     err, dbg_data, m_ddram[7'h11]);
        end
    endtask

    task automatic test_invalid_addr();
        logic [7:0] d;
        logic [3:0] tr;
        logic [7:0] exp;
        bus_write(1'b0, 8'h85);  m_write(1'b0, 8'h85);  wait_idle();
        bus_write(1'b0, 8'hB0);  m_write(1'b0, 8'hB0);  wait_idle();
        checks++;
        if (err !== 1'b1 || ac !== 7'h05) begin
            errors++;
            $display("FAIL invalid_addr: err=%b ac=%h required 1 05", err, ac);
        end
        exp = m_ddram[m_ac];
        bus_read(1'b1, d, tr);
        m_ac = m_step(m_ac, m_id);
        checks++;
        if (d !== exp || ac !== 7'h06) begin
            errors++;
            $display("FAIL data_read: got %h ac=%h required %h 06", d, ac, exp);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] exp;
        logic [3:0] tr;
        int op;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1: begin
                    d = 8'($urandom_range(0, 255));
                    bus_write(1'b1, d);  m_write(1'b1, d);
                end
                2: begin
                    d = 8'h80 | 8'($urandom_range(0, 127));
                    bus_write(1'b0, d);  m_write(1'b0, d);
                end
                3: begin
                    d = 8'h04 | 8'($urandom_range(0, 3));
                    bus_write(1'b0, d);  m_write(1'b0, d);
                end
                4: begin
                    d = 8'h08 | 8'($urandom_range(0, 7));
                    bus_write(1'b0, d);  m_write(1'b0, d);
                end
                5: begin
                    exp = m_ddram[m_ac];
                    bus_read(1'b1, d, tr);
                    m_ac = m_step(m_ac, m_id);
                    checks++;
                    if (d !== exp) begin
                        errors++;
                        $display("FAIL rand_data_read[%0d]: got %h required %h", i, d, exp);
                    end
                end
                6: begin
                    exp = {1'b0, m_ac};
                    bus_read(1'b0, d, tr);
                    checks++;
                    if (d !== exp) begin
                        errors++;
                        $display("FAIL rand_status[%0d]: got %h required %h", i, d, exp);
                    end
                end
                default: begin
                    d = 8'h02 | 8'($urandom_range(0, 1));
                    bus_write(1'b0, d);  m_write(1'b0, d);
                end
            endcase
            wait_idle();
            dbg_addr = addr_of($urandom_range(0, 79));
            #1;
            checks++;
            if (ac !== m_ac || err !== m_err || display_on !== m_disp || dbg_data !== m_ddram[dbg_addr]) begin
                errors++;
                $display("FAIL rand_state[%0d]: ac=%h err=%b disp=%b ddram[%h]=%h required %h %b %b %h",
                         i, ac, err, display_on, dbg_addr, dbg_data, m_ac, m_err, m_disp,
                         m_ddram[dbg_addr]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        lcd_e = 1'b0;
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
        lcd_data_in = 8'h00;
        dbg_addr = 7'h00;
        test_reset();
        test_write_basic();
        test_wrap();
        test_clear();
        test_busy_write();
        test_invalid_addr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
